counter_updown_n: RTL
=====================

// Module: counter_updown_n
// PURPOSE
//  Parametrised synchronous up/down counter: next generation of the 74193-style counter model.
//  Single clock, configurable width and modulus, synchronous parallel load, count enable.
//  Active-low terminal-count outputs allow cascading into multi-digit chains.
//  Used by the CPU model for program/stack pointers and BCD-style timers.
// PARAMETERS
//  WIDTH    4          counter width in bits (1..32)
//  MODULUS  2**WIDTH   count range 0..MODULUS-1; MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk      in   1      clock, all state changes on rising edge
//  clr      in   1      reset, asynchronous, active-high; forces q to 0
//  n_load   in   1      synchronous parallel load, active-low
//  up       in   1      count-up request (level, sampled on clk)
//  down     in   1      count-down request (level, sampled on clk)
//  cen      in   1      count enable, active-high; cascade input (tie 1 on first stage)
//  d        in   WIDTH  parallel load data
//  q        out  WIDTH  counter value
//  n_co     out  1      carry out, active-low, combinational
//  n_bo     out  1      borrow out, active-low, combinational
// BEHAVIOUR
//  - Reset: clr=1 forces q=0 immediately, without a clock; while clr=1, n_load/up/down are ignored.
//  - Outputs during reset: n_co=1, n_bo=1.
//  - Priority at each rising clk edge (clr=0): n_load=0 > count > hold.
//  - Load: q <= d when d < MODULUS, else q <= MODULUS-1. Load ignores cen, up and down.
//  - Count is performed only when cen=1 and exactly one of up/down is 1:
//    - up:   q <= (q == MODULUS-1) ? 0 : q+1
//    - down: q <= (q == 0) ? MODULUS-1 : q-1
//  - up=1 and down=1 together, or both 0, or cen=0: q holds.
//  - n_co = ~(cen & up & ~down & (q == MODULUS-1)); goes low in the same cycle as the wrap edge.
//  - n_bo = ~(cen & down & ~up & q == 0).
//  - n_co and n_bo are never 0 simultaneously. Both are 1 while n_load=0.
//  - Latency: q updates one clk edge after the request. Terminal-count outputs are zero-latency (combinational on q/inputs).
//  - Cascading: connect next stage cen = ~n_co | ~n_bo of this stage, with shared up/down.
//  - clr asserted mid-count: q=0 asynchronously.
//  - clr released: first count edge takes effect on the next rising edge with clr=0.
//  - Arithmetic is performed in WIDTH bits. No intermediate value exceeds MODULUS-1.
// CONFIGURATION
//  - COUNTER_UPDOWN_SAT_EN defined: saturating mode.
//    - up at q==MODULUS-1 holds q; down at q==0 holds q.
//    - n_co/n_bo still assert at the terminal value while counting is requested.
//  - COUNTER_UPDOWN_SAT_EN undefined (default): wrap-around as described above.
// STRUCTURE
//  - Shared header counter_defs.vh:
//    - localparams CNT_DIR_HOLD/CNT_DIR_UP/CNT_DIR_DOWN (2-bit direction encoding)
//    - function cnt_clamp(d, MODULUS) used by the load path
//  - Sub-module counter_tc_detect (WIDTH, MODULUS):
//    - inputs q, dir, cen
//    - outputs n_co, n_bo
//    - purely combinational
//  - Top level holds the register, the direction decode and the next-value mux.
// TESTING
//  1. WIDTH=4, MODULUS=16, clr=1 for 1 cycle then 0: q=0, n_co=1, n_bo=1.
//     Then up=1 for 20 edges: q steps 0..15,0..3. n_co=0 only while q=15.
//  2. Load d=4'b1011 with n_load=0 for one edge -> q=11, n_co=1, n_bo=1.
//     Then down=1 for 27 edges -> q reaches 0 then wraps to 15. n_bo=0 only while q=0.
//  3. MODULUS=10, q=9, up=1 -> next q=0, n_co=0 before the edge.
//     Load d=13 -> q=9 (clamp).
//  4. up=1 and down=1 at q=5 -> q stays 5, n_co=1, n_bo=1.
//     cen=0 with up=1 -> q holds.
//  5. clr pulse between clock edges while counting at q=7 -> q=0 immediately, without an edge.
//     n_load=0 with clr=1 -> q stays 0.
//  6. COUNTER_UPDOWN_SAT_EN defined:
//     - q=15, up=1 for 3 edges -> q=15, n_co=0.
//     - q=0, down=1 -> q=0, n_bo=0.
//  Two cascaded 4-bit stages counting up from 8'h0F: one edge -> 8'h10.

Source files
------------

// File: rtl/counter_updown_n_pkg.sv
// Shared definitions for the counter_updown_n slice: direction encoding
// and the load-path clamp.
package counter_updown_n_pkg;

    localparam logic [1:0] CNT_DIR_HOLD = 2'b00;
    localparam logic [1:0] CNT_DIR_UP   = 2'b01;
    localparam logic [1:0] CNT_DIR_DOWN = 2'b10;

    // Loaded values above the count range land on the top count.
    function automatic longint unsigned cnt_clamp(input longint unsigned d,
                                                  input longint unsigned modulus);
        return (d < modulus) ? d : modulus - 64'd1;
    endfunction

endpackage

// File: rtl/counter_updown_n_tc_detect.sv
// Terminal-count detector for counter_updown_n. Purely combinational,
// active-low carry/borrow for cascading into further stages.
module counter_updown_n_tc_detect
    import counter_updown_n_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       dir,
    input  logic             cen,
    output logic             n_co,
    output logic             n_bo
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 64'd1);

    // dir is one-hot or hold, so carry and borrow cannot assert together.
    assign n_co = ~(cen && (dir == CNT_DIR_UP)   && (q == Q_MAX));
    assign n_bo = ~(cen && (dir == CNT_DIR_DOWN) && (q == '0));

endmodule

// File: rtl/counter_updown_n.sv
// Parametrised up/down counter with synchronous clamped load, count enable
// and active-low combinational carry/borrow for cascading.
// Build option: COUNTER_UPDOWN_SAT_EN selects saturation at 0 and
// MODULUS-1 instead of wrap-around.
module counter_updown_n
    import counter_updown_n_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             n_load,
    input  logic             up,
    input  logic             down,
    input  logic             cen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             n_co,
    output logic             n_bo
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 64'd1);

    logic [1:0]       dir;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_val;
    logic             tc_cen;

    assign load_val = WIDTH'(cnt_clamp(64'(d), MODULUS));

    // Direction decode: conflicting or absent requests mean hold.
    always_comb begin
        dir = CNT_DIR_HOLD;
        if (up && !down)
            dir = CNT_DIR_UP;
        else if (down && !up)
            dir = CNT_DIR_DOWN;
    end

    // Next-value mux: load beats count beats hold.
    always_comb begin
        q_next = q_r;
        if (!n_load) begin
            q_next = load_val;
        end else if (cen) begin
            case (dir)
                CNT_DIR_UP: begin
                    if (q_r == Q_MAX)
`ifdef COUNTER_UPDOWN_SAT_EN
                        q_next = q_r;
`else
                        q_next = '0;
`endif
                    else
                        q_next = q_r + WIDTH'(1);
                end
                CNT_DIR_DOWN: begin
                    if (q_r == '0)
`ifdef COUNTER_UPDOWN_SAT_EN
                        q_next = q_r;
`else
                        q_next = Q_MAX;
`endif
                    else
                        q_next = q_r - WIDTH'(1);
                end
                default: q_next = q_r;
            endcase
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q_r <= '0;
        else
            q_r <= q_next;
    end

    // Terminal counts stay inactive while loading or held in clear.
    assign tc_cen = cen & n_load & ~clr;

    counter_updown_n_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc (
        .q    (q_r),
        .dir  (dir),
        .cen  (tc_cen),
        .n_co (n_co),
        .n_bo (n_bo)
    );

    assign q = q_r;

endmodule
